// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants for the instruction-fetch stage: reset PC, bubble encoding,
// HALT opcode and the fetch FSM state encodings.
// Optional feature macro used by the fetch stage: FETCH_ALIGN_CHK_EN.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int          DATA_W    = 16;
  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  HALT_OPC  = 5'b00000;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN   = RUN,
    ST_DRAIN = DRAIN,
    ST_HALT  = HALT
  } fetch_state_e;

  function automatic logic is_halt(input logic [DATA_W-1:0] word);
    return word[15:11] == HALT_OPC;
  endfunction

endpackage

// File: rtl/fetch_if_if.sv
// -----------------------------------------------------------------------------
// fetch_if_if
// Instruction-memory request/ready bus between the fetch stage and memory.
//   imem_req   fetch request (master -> slave)
//   imem_addr  fetch address (master -> slave)
//   imem_rdata instruction word, valid when imem_ready=1 (slave -> master)
//   imem_ready access completes this cycle (slave -> master)
// -----------------------------------------------------------------------------
interface fetch_if_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/fetch_if_latch.sv
// -----------------------------------------------------------------------------
// if_id_latch
// IF/ID pipeline register: {instr, curr_pc, new_addr, valid}.
//   clk, rst   clock, synchronous active-low reset
//   hold       keep the current contents (hazard stall)
//   flush      insert a bubble, overriding hold (redirect)
//   load       capture d_instr/d_pc as a valid instruction
//   d_instr    fetched word
//   d_pc       address of the fetched word
//   instr, curr_pc, new_addr, valid   registered IF/ID outputs
// With none of hold/flush/load asserted a bubble is inserted. A bubble only
// replaces instr/valid; curr_pc/new_addr keep their last values.
// -----------------------------------------------------------------------------
module if_id_latch
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic        load,
  input  logic [15:0] d_instr,
  input  logic [15:0] d_pc,
  output logic [15:0] instr,
  output logic [15:0] curr_pc,
  output logic [15:0] new_addr,
  output logic        valid
);

  logic [15:0] instr_p1;
  logic [15:0] pc_p1;
  logic [15:0] naddr_p1;
  logic        vld_p1;

  // ---- IF -> ID boundary ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_p1 <= NOP_INSTR;
      pc_p1    <= RESET_PC;
      naddr_p1 <= RESET_PC + 16'd2;
      vld_p1   <= 1'b0;
    end else if (flush) begin
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (hold) begin
      instr_p1 <= instr_p1;
      vld_p1   <= vld_p1;
    end else if (load) begin
      instr_p1 <= d_instr;
      pc_p1    <= d_pc;
      naddr_p1 <= d_pc + 16'd2;
      vld_p1   <= 1'b1;
    end else begin
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end
  end

  assign instr    = instr_p1;
  assign curr_pc  = pc_p1;
  assign new_addr = naddr_p1;
  assign valid    = vld_p1;

endmodule

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
// Instruction-fetch stage: owns the PC, fetches one 16-bit word per cycle
// through a request/ready handshake and feeds the IF/ID register. Handles
// hazard stalls, branch/jump redirects (draining an in-flight access when
// needed), memory wait states and HALT.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   stall               hold pc and IF/ID
//   redirect/redirect_pc taken branch/jump from decode
//   imem (master)       imem_req/imem_addr out, imem_rdata/imem_ready in
//   instr/currPC/new_addr/valid  registered IF/ID outputs
//   halted              fetch stopped by HALT
//   err                 sticky misaligned-fetch error
// Optional feature: define FETCH_ALIGN_CHK_EN to flag odd fetch addresses
// (err set, fetch halted). Without it addresses are forced even and err is 0.
// -----------------------------------------------------------------------------
module fetch_if
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [15:0]        redirect_pc,
  fetch_if_if.master         imem,
  output logic [15:0]        instr,
  output logic [15:0]        currPC,
  output logic [15:0]        new_addr,
  output logic               valid,
  output logic               halted,
  output logic               err
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  pend_q, pend_d;
  logic         halted_q;
  logic         req;
  logic         lat_hold, lat_flush, lat_load;

  function automatic logic [15:0] align_pc(input logic [15:0] a);
`ifdef FETCH_ALIGN_CHK_EN
    return a;
`else
    return {a[15:1], 1'b0};
`endif
  endfunction

`ifdef FETCH_ALIGN_CHK_EN
  logic misaligned;
  logic set_err;
  logic err_q;

  assign misaligned     = pc_q[0];
  assign req            = rst && ((state_q == ST_DRAIN) ||
                                  (state_q == ST_RUN && !misaligned));
  assign imem.imem_addr = pc_q;
  assign err            = err_q;
`else
  assign req            = rst && (state_q == ST_RUN || state_q == ST_DRAIN);
  assign imem.imem_addr = {pc_q[15:1], 1'b0};
  assign err            = 1'b0;
`endif

  assign imem.imem_req = req;

  // Next-state / IF/ID control. Priority: redirect > stall > memory.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    lat_hold  = 1'b0;
    lat_flush = 1'b0;
    lat_load  = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    set_err   = 1'b0;
`endif
    unique case (state_q)
      ST_RUN: begin
        if (redirect) begin
          lat_flush = 1'b1;
          // An access left hanging must finish before the new target is fetched.
          if (imem.imem_ready || !req) begin
            pc_d = align_pc(redirect_pc);
          end else begin
            pend_d  = align_pc(redirect_pc);
            state_d = ST_DRAIN;
          end
        end
`ifdef FETCH_ALIGN_CHK_EN
        else if (misaligned) begin
          set_err  = 1'b1;
          state_d  = ST_HALT;
          lat_hold = stall;
        end
`endif
        else if (stall) begin
          // Any word returned now is discarded; same pc re-fetched later.
          lat_hold = 1'b1;
        end else if (imem.imem_ready) begin
          lat_load = 1'b1;
          pc_d     = pc_q + 16'd2;
          if (is_halt(imem.imem_rdata)) state_d = ST_HALT;
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          lat_flush = 1'b1;
          if (imem.imem_ready) begin
            pc_d    = align_pc(redirect_pc);
            state_d = ST_RUN;
          end else begin
            pend_d = align_pc(redirect_pc);
          end
        end else begin
          lat_hold = stall;
          if (imem.imem_ready) begin
            pc_d    = pend_q;
            state_d = ST_RUN;
          end
        end
      end
      ST_HALT: begin
        if (redirect) begin
          lat_flush = 1'b1;
          pc_d      = align_pc(redirect_pc);
          state_d   = ST_RUN;
        end else begin
          lat_hold = stall;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // ---- PC / control registers ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  // pend_pc is only read in DRAIN, which is always entered with it written.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

`ifdef FETCH_ALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst)         err_q <= 1'b0;
    else if (set_err) err_q <= 1'b1;
  end
`endif

  assign halted = halted_q;

  if_id_latch u_if_id (
    .clk      (clk),
    .rst      (rst),
    .hold     (lat_hold),
    .flush    (lat_flush),
    .load     (lat_load),
    .d_instr  (imem.imem_rdata),
    .d_pc     (pc_q),
    .instr    (instr),
    .curr_pc  (currPC),
    .new_addr (new_addr),
    .valid    (valid)
  );

endmodule
